// File: rtl/ysyx_23060061_ifu.sv
// ysyx_23060061_ifu - instruction fetch unit for the multicycle NPC core.
//
// Holds the PC and issues one read per instruction on an AXI4-Lite-style
// read channel. It hands the fetched word and its PC to decode over a
// valid/ready handshake, then waits for the write-back redirect before it
// fetches again. At most one instruction is in flight at any time.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   araddr/arvalid    read request (address is always the current pc)
//   arready           memory accepts the request
//   rdata/rresp       read data and response code (2'b00 = OKAY)
//   rvalid/rready     read data handshake
//   out_inst/out_pc   fetched word and the address it came from
//   out_fault         fetch returned a non-OKAY response
//   out_valid         out_* valid
//   out_ready         decode accepts out_*
//   npc/npc_valid     next-pc redirect from write-back (single-cycle pulse)
module ysyx_23060061_ifu #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_fault,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [ADDR_W-1:0] npc,
    input  logic              npc_valid
);

    typedef enum logic [1:0] {
        S_AR  = 2'd0,
        S_R   = 2'd1,
        S_OUT = 2'd2,
        S_NPC = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d;

    // npc low bits are discarded on purpose: misalignment is trapped downstream.
    logic npc_unused_s;
    assign npc_unused_s = ^npc[1:0];

    // Next-state and datapath update for the fetch sequence.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        case (state_q)
            S_AR: begin
                // arvalid is implied high in this state, so arready alone completes the handshake.
                if (arready) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (rvalid) begin
                    inst_d  = rdata;
                    fault_d = (rresp != 2'b00);
                    state_d = S_OUT;
                end else begin
                    state_d = S_R;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_NPC;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_NPC: begin
                // Redirects outside this state never reach pc.
                if (npc_valid) begin
                    pc_d    = {npc[ADDR_W-1:2], 2'b00};
                    state_d = S_AR;
                end else begin
                    state_d = S_NPC;
                end
            end
            default: begin
                state_d = S_AR;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_AR;
            pc_q    <= RESET_PC;
            inst_q  <= {DATA_W{1'b0}};
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // Handshake valids come from the state register only; rst masks them
    // so nothing is requested or presented while reset is held.
    assign arvalid   = (state_q == S_AR)  && !rst;
    assign rready    = (state_q == S_R)   && !rst;
    assign out_valid = (state_q == S_OUT) && !rst;

    // pc is frozen from request to redirect, so it doubles as out_pc.
    assign araddr    = pc_q;
    assign out_pc    = pc_q;
    assign out_inst  = inst_q;
    assign out_fault = fault_q;

endmodule
